// File: rtl/cipher_arbiter.sv
// Round-robin scheduler sharing one 32-round encryption core among NUM_REQ requesters.
// Define CIPHER_ARBITER_TIMEOUT_EN to build in the RUN watchdog (done+err after TIMEOUT cycles).
//
// state | meaning
// IDLE  | waiting for a request; grants and latches operands on the winning requester
// LOAD  | core_start held low for one edge so the core reloads key/plaintext
// RUN   | core_start high; waits for core_end (or watchdog expiry)
module cipher_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 48
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [128*NUM_REQ-1:0] plain_in,
  input  logic [64*NUM_REQ-1:0]  key_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [0:127]           cipher_out,
  output logic                   busy,
  output logic [0:127]           core_plain,
  output logic [0:63]            core_key,
  output logic                   core_start,
  input  logic                   core_end,
  input  logic [0:127]           core_cipher
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [0:127]         cipher_q, cipher_d;
  logic [0:127]         plain_q, plain_d;
  logic [0:63]          key_q, key_d;
  logic                 start_q, start_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;

  logic                 pick_vld;
  logic [ID_W-1:0]      pick_id;
  logic [ID_W-1:0]      cand;
  int                   rr_idx;
  logic [127:0]         sel_plain;
  logic [63:0]          sel_key;
  logic                 timeout_hit;

  // Scan from ptr+1 upward; descending loop so the nearest requester is written last.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    cand     = '0;
    rr_idx   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      rr_idx = (int'(ptr_q) + k) % NUM_REQ;
      cand   = ID_W'(rr_idx);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_comb begin
    sel_plain = '0;
    sel_key   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_id == ID_W'(i)) begin
        sel_plain = plain_in[i*128 +: 128];
        sel_key   = key_in[i*64 +: 64];
      end
    end
  end

`ifdef CIPHER_ARBITER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;

  // Down-counter reloaded while in LOAD, i.e. on every entry to RUN.
  always_comb begin
    tmr_d = tmr_q;
    if (state_q == LOAD) begin
      tmr_d = TMR_W'(TIMEOUT - 1);
    end else if (state_q == RUN && tmr_q != '0) begin
      tmr_d = tmr_q - 1'b1;
    end
  end

  assign timeout_hit = (state_q == RUN) && (tmr_q == '0);
  assign err_d       = timeout_hit && !core_end;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = '0;
    done_d   = '0;
    cipher_d = cipher_q;
    plain_d  = plain_q;
    key_d    = key_q;
    start_d  = start_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        start_d = 1'b0;
        if (pick_vld) begin
          grant_d[pick_id] = 1'b1;
          plain_d          = sel_plain;
          key_d            = sel_key;
          id_d             = pick_id;
          ptr_d            = pick_id;
          state_d          = LOAD;
        end
      end
      LOAD: begin
        start_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (core_end) begin
          cipher_d      = core_cipher;
          done_d[id_q]  = 1'b1;
          start_d       = 1'b0;
          state_d       = IDLE;
        end else if (timeout_hit) begin
          done_d[id_q]  = 1'b1;
          start_d       = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        start_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      cipher_q <= '0;
      plain_q  <= '0;
      key_q    <= '0;
      start_q  <= 1'b0;
      id_q     <= '0;
      ptr_q    <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      cipher_q <= cipher_d;
      plain_q  <= plain_d;
      key_q    <= key_d;
      start_q  <= start_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign cipher_out = cipher_q;
  assign core_plain = plain_q;
  assign core_key   = key_q;
  assign core_start = start_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cipher_arbiter.sv
// Directed bench for cipher_arbiter with a behavioural 33-cycle core model.
module tb_cipher_arbiter;

  localparam int NR = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [128*NR-1:0] plain_in;
  logic [64*NR-1:0]  key_in;
  logic [NR-1:0]   grant, done;
  logic            err, busy, core_start, core_end;
  logic [0:127]    cipher_out, core_plain, core_cipher;
  logic [0:63]     core_key;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int ccnt   = 0;
  int overlap = 0;
  int done_cnt = 0;
  bit core_dead = 1'b0;

  logic [127:0] p_tab [NR];
  logic [63:0]  k_tab [NR];
  logic [127:0] last_exp;

  cipher_arbiter #(.NUM_REQ(NR), .TIMEOUT(48)) dut (
    .clock(clock), .reset(reset), .req(req), .plain_in(plain_in), .key_in(key_in),
    .grant(grant), .done(done), .err(err), .cipher_out(cipher_out), .busy(busy),
    .core_plain(core_plain), .core_key(core_key), .core_start(core_start),
    .core_end(core_end), .core_cipher(core_cipher)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [127:0] fcore(input logic [127:0] p, input logic [63:0] k);
    return {p[63:0] ^ k, p[127:64] + k};
  endfunction

  // Core model: core_end rises at the 33rd negedge that sees start high.
  always @(negedge clock) begin
    if (reset || !core_start) begin
      ccnt     = 0;
      core_end = 1'b0;
    end else begin
      ccnt = ccnt + 1;
      if (ccnt == 33 && !core_dead) begin
        core_end    = 1'b1;
        core_cipher = fcore(core_plain, core_key);
      end
    end
  end

  always @(negedge clock) begin
    if (grant != '0 && done != '0) overlap++;
    if (done != '0) done_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [127:0] p, input logic [63:0] k);
    plain_in[i*128 +: 128] = p;
    key_in[i*64 +: 64]     = k;
  endtask

  task automatic wait_grant(output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (grant != '0) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("grant_seen", 128'd0, 128'd1);
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (done != '0) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("done_seen", 128'd0, 128'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  int g, d, prev, dc, busy_lo;

  initial begin
    reset       = 1'b1;
    req         = '0;
    plain_in    = '0;
    key_in      = '0;
    core_end    = 1'b0;
    core_cipher = '0;
    for (int i = 0; i < NR; i++) begin
      p_tab[i] = {32'h1111_0000 + 32'(i), 32'hdead_beef, 32'h0bad_f00d ^ 32'(i << 4), 32'h1234_5678};
      k_tab[i] = {32'hcafe_0000 | 32'(i), 32'h5a5a_a5a5};
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_grant", 128'(grant), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err_busy_start", {125'd0, err, busy, core_start}, 128'd0);
    chk("rst_cipher", cipher_out, 128'd0);
    chk("rst_core_ops", {core_plain ^ 128'(core_key)}, 128'd0);

    // single request from requester 1
    set_op(1, p_tab[1], k_tab[1]);
    req = 4'b0010;
    wait_grant(g);
    chk("t1_grant", 128'(grant), 128'(4'b0010));
    chk("t1_core_plain", core_plain, p_tab[1]);
    chk("t1_core_key", 128'(core_key), 128'(k_tab[1]));
    req = '0;
    @(negedge clock);
    chk("t1_busy", 128'(busy), 128'd1);
    wait_done(d);
    chk("t1_done", 128'(done), 128'(4'b0010));
    chk("t1_err", 128'(err), 128'd0);
    chk("t1_cipher", cipher_out, fcore(p_tab[1], k_tab[1]));
    chk("t1_latency", 128'(d - g), 128'd34);
    @(negedge clock);
    chk("t1_done_pulse", 128'(done), 128'd0);
    chk("t1_idle", 128'(busy), 128'd0);

    // contention: all four requesting continuously
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, p_tab[i], k_tab[i]);
    req  = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk($sformatf("t2_grant%0d", k), 128'(grant), 128'(1) << (k % NR));
      if (k > 0) chk($sformatf("t2_spacing%0d", k), 128'(g - prev), 128'd35);
      prev = g;
      if (k == 4) req = '0;
      wait_done(d);
      chk($sformatf("t2_cipher%0d", k), cipher_out, fcore(p_tab[k % NR], k_tab[k % NR]));
    end
    chk("t2_overlap", 128'(overlap), 128'd0);

    // operand isolation: slice 1 changes right after grant
    set_op(1, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 64'h0f0f_0f0f_f0f0_f0f0);
    req = 4'b0010;
    wait_grant(g);
    chk("t3_grant", 128'(grant), 128'(4'b0010));
    req = '0;
    set_op(1, 128'hffff_eeee_dddd_cccc_bbbb_aaaa_9999_8888, 64'h1);
    @(negedge clock);
    chk("t3_core_plain", core_plain, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
    wait_done(d);
    chk("t3_cipher", cipher_out,
        fcore(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 64'h0f0f_0f0f_f0f0_f0f0));
    last_exp = fcore(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 64'h0f0f_0f0f_f0f0_f0f0);

    // reset in the middle of a job
    req = 4'b0100;
    wait_grant(g);
    chk("t4_grant", 128'(grant), 128'(4'b0100));
    req = '0;
    repeat (19) @(negedge clock);
    chk("t4_start_before", 128'(core_start), 128'd1);
    #2 reset = 1'b1;
    #1;
    chk("t4_start_async", 128'(core_start), 128'd0);
    chk("t4_busy_async", 128'(busy), 128'd0);
    dc = done_cnt;
    @(negedge clock);
    reset = 1'b0;
    repeat (50) @(negedge clock);
    chk("t4_no_done", 128'(done_cnt - dc), 128'd0);
    req = 4'b1000;
    wait_grant(g);
    chk("t4_grant_after", 128'(grant), 128'(4'b1000));
    req = '0;
    wait_done(d);
    chk("t4_done_after", 128'(done), 128'(4'b1000));
    last_exp = fcore(p_tab[3], k_tab[3]);

    // dead core
    core_dead = 1'b1;
    req = 4'b0001;
    wait_grant(g);
    chk("t5_grant", 128'(grant), 128'(4'b0001));
    req = '0;
`ifdef CIPHER_ARBITER_TIMEOUT_EN
    wait_done(d);
    chk("t5_done", 128'(done), 128'(4'b0001));
    chk("t5_err", 128'(err), 128'd1);
    chk("t5_latency", 128'(d - g), 128'd49);
    chk("t5_cipher_held", cipher_out, last_exp);
    @(negedge clock);
    chk("t5_err_pulse", 128'(err), 128'd0);
    chk("t5_idle", 128'(busy), 128'd0);
`else
    dc      = done_cnt;
    busy_lo = 0;
    repeat (200) begin
      @(negedge clock);
      if (!busy) busy_lo++;
    end
    chk("t5_busy_held", 128'(busy_lo), 128'd0);
    chk("t5_no_done", 128'(done_cnt - dc), 128'd0);
    chk("t5_start_held", 128'(core_start), 128'd1);
    chk("t5_err_tied", 128'(err), 128'd0);
    chk("t5_cipher_held", cipher_out, last_exp);
`endif
    core_dead = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
